scytale_frame_feeder: RTL and testbench
=======================================

SCYTALE_FRAME_FEEDER -- requirements
Module: scytale_frame_feeder

Interface
REQ-001 Parameter D_WIDTH, default 8, data byte width.
REQ-002 Parameter KEY_WIDTH, default 8, key field width.
REQ-003 Parameter MAX_NOF_CHARS, default 50, maximum payload bytes per frame.
REQ-004 Parameter START_DECRYPTION_TOKEN, default 8'hFA, end-of-payload token sent downstream.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 data_i  input  D_WIDTH  upstream byte.
REQ-008 valid_i  input  1  data_i qualifier, one byte per asserted cycle.
REQ-009 dec_busy_i  input  1  busy from the downstream scytale decryptor.
REQ-010 data_o  output  D_WIDTH  byte to the decryptor.
REQ-011 valid_o  output  1  data_o qualifier.
REQ-012 key_N_o  output  KEY_WIDTH  frame key N, held stable from DRAIN to IDLE return.
REQ-013 key_M_o  output  KEY_WIDTH  frame key M, same hold rule.
REQ-014 busy_o  output  1  high while the block cannot accept upstream bytes.
REQ-015 err_o  output  1  one-cycle pulse on frame rejection.

Function
REQ-016 Frame format SHALL be: key_N byte, key_M byte, then exactly key_N*key_M payload bytes.
REQ-017 FSM states SHALL be IDLE, HDR_M, LOAD, DRAIN, TOKEN, WAIT_HI, WAIT_LO.
REQ-018 IDLE: valid_i captures key_N, go HDR_M; HDR_M: valid_i captures key_M, go LOAD.
REQ-019 Product key_N*key_M SHALL be computed at 2*KEY_WIDTH bits; if 0 or >MAX_NOF_CHARS on HDR_M exit, pulse err_o next cycle and return to IDLE instead of LOAD.
REQ-020 LOAD: each valid_i byte SHALL be written to buffer at write index 0,1,...; after the last byte, go DRAIN next cycle.
REQ-021 busy_o SHALL be 0 in IDLE, HDR_M, LOAD and 1 in all other states; bytes with valid_i while busy_o=1 SHALL be discarded.
REQ-022 DRAIN: one byte per cycle in write order with valid_o=1, no gaps; first byte one cycle after DRAIN entry.
REQ-023 TOKEN: one cycle, data_o=START_DECRYPTION_TOKEN, valid_o=1; then WAIT_HI.
REQ-024 WAIT_HI waits for dec_busy_i=1, WAIT_LO waits for dec_busy_i=0, then IDLE; frame latency input-last-byte to first valid_o SHALL be 2 cycles.
REQ-025 valid_o SHALL be 0 outside DRAIN and TOKEN; data_o SHALL hold its last value when valid_o=0.
REQ-026 A token value appearing inside payload SHALL be stored as ordinary data.
REQ-027 Read/write indices SHALL clear on every IDLE entry; no wrap-around within a frame.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, data_o=0, valid_o=0, key_N_o=0, key_M_o=0, busy_o=0, err_o=0, indices=0, aborting any frame in progress.
REQ-029 Buffer contents need not be reset.

Configuration
REQ-030 Macro SCYTALE_FEEDER_CHECKSUM_EN defined: a CHECK state after LOAD consumes one extra byte that SHALL equal XOR of key_N, key_M and all payload bytes; mismatch pulses err_o and returns to IDLE without DRAIN; match proceeds to DRAIN (latency 2 cycles from checksum byte).
REQ-031 Macro undefined: no CHECK state, no checksum byte, REQ-020 timing applies.

Structure
REQ-032 Package scytale_pkg SHALL hold the FSM state enum, default START_DECRYPTION_TOKEN and default width constants.
REQ-033 Sub-module scytale_byte_buffer (MAX_NOF_CHARS x D_WIDTH, one write port, one read port, registered read) SHALL hold the payload.

Verification
REQ-034 Frame 03,02,"ABCDEF" -> valid_o bytes A..F on 6 consecutive cycles then FA; key_N_o=3, key_M_o=2; busy_o=1 from DRAIN until dec_busy_i high then low.
REQ-035 Header 00,05 -> err_o pulse, no valid_o, next byte accepted as key_N.
REQ-036 Header 08,08 (64>50) -> err_o pulse, return to IDLE.
REQ-037 Payload containing FA (02,01,FA,41) -> outputs FA,41,FA with valid_o=1 on 3 cycles.
REQ-038 rst_n low during DRAIN of byte 3 -> valid_o=0, busy_o=0 same cycle; next frame processed correctly.
REQ-039 With SCYTALE_FEEDER_CHECKSUM_EN: 01,02,10,20,checksum 33 -> drains 10,20,FA; checksum 34 -> err_o pulse, no valid_o.

Source files
------------

// File: rtl/scytale_pkg.sv
// Shared definitions for the scytale frame feeder: default widths, the
// end-of-payload token and the feeder FSM state encoding.
// Optional checksum support is enabled with SCYTALE_FEEDER_CHECKSUM_EN.
package scytale_pkg;

  localparam int DEF_D_WIDTH       = 8;
  localparam int DEF_KEY_WIDTH     = 8;
  localparam int DEF_MAX_NOF_CHARS = 50;

  localparam logic [7:0] DEF_START_DECRYPTION_TOKEN = 8'hFA;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR_M   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_TOKEN   = 3'd4,
    ST_WAIT_HI = 3'd5,
`ifdef SCYTALE_FEEDER_CHECKSUM_EN
    ST_WAIT_LO = 3'd6,
    ST_CHECK   = 3'd7
`else
    ST_WAIT_LO = 3'd6
`endif
  } feeder_state_t;

  // Index width able to address every buffer slot; never below one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/scytale_byte_buffer.sv
// Payload store for one frame: simple dual-port RAM, one write port and one
// read port whose data is registered. Storage is not reset; only the read
// register is, so the feeder's data_o comes out of reset at zero.
module scytale_byte_buffer
  import scytale_pkg::*;
#(
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int DEPTH   = DEF_MAX_NOF_CHARS,
  parameter int ADDR_W  = idx_width(DEF_MAX_NOF_CHARS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);

  logic [D_WIDTH-1:0] mem [DEPTH];

  // Write port: store the incoming payload byte at the write index.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: registered read that holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/scytale_frame_feeder.sv
// Frame feeder in front of the scytale decryptor. Collects a frame made of
// key_N, key_M and key_N*key_M payload bytes, replays the payload back to
// back followed by the start-decryption token, then waits for the decryptor
// to raise and drop its busy flag before accepting the next frame.
// Defining SCYTALE_FEEDER_CHECKSUM_EN adds a trailing XOR checksum byte that
// must match before the payload is released.
module scytale_frame_feeder
  import scytale_pkg::*;
#(
  parameter int D_WIDTH       = DEF_D_WIDTH,
  parameter int KEY_WIDTH     = DEF_KEY_WIDTH,
  parameter int MAX_NOF_CHARS = DEF_MAX_NOF_CHARS,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(DEF_START_DECRYPTION_TOKEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic                 dec_busy_i,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic [KEY_WIDTH-1:0] key_N_o,
  output logic [KEY_WIDTH-1:0] key_M_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int IDX_W  = idx_width(MAX_NOF_CHARS);
  localparam int PROD_W = 2 * KEY_WIDTH;

  feeder_state_t      state;
  logic [IDX_W-1:0]   wr_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   last_idx;
  logic               tok_sel;
  logic [KEY_WIDTH-1:0] hdr_key;
  logic [PROD_W-1:0]  product;
  logic               wr_en;
  logic               rd_en;
  logic [D_WIDTH-1:0] rd_data;
`ifdef SCYTALE_FEEDER_CHECKSUM_EN
  logic [D_WIDTH-1:0] xor_acc;
`endif

  // The key_M candidate is the byte currently on data_i; the product is
  // formed at full width so large keys cannot alias into a legal length.
  assign hdr_key = KEY_WIDTH'(data_i);
  assign product = PROD_W'(key_N_o) * PROD_W'(hdr_key);
  assign wr_en   = (state == ST_LOAD) && valid_i;
  assign rd_en   = (state == ST_DRAIN);

  // Output byte is either the buffer's registered read or the token; both
  // sources are registers, so data_o holds whenever neither changes.
  assign data_o  = tok_sel ? START_DECRYPTION_TOKEN : rd_data;

  scytale_byte_buffer #(
    .D_WIDTH (D_WIDTH),
    .DEPTH   (MAX_NOF_CHARS),
    .ADDR_W  (IDX_W)
  ) u_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_idx),
    .wr_data (data_i),
    .rd_en   (rd_en),
    .rd_addr (rd_idx),
    .rd_data (rd_data)
  );

  // Frame FSM with registered handshake outputs; outputs trail the state by
  // one cycle because the buffer read is registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      key_N_o  <= '0;
      key_M_o  <= '0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      last_idx <= '0;
      tok_sel  <= 1'b0;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
      err_o    <= 1'b0;
`ifdef SCYTALE_FEEDER_CHECKSUM_EN
      xor_acc  <= '0;
`endif
    end else begin
      valid_o <= 1'b0;
      err_o   <= 1'b0;
      case (state)
        ST_IDLE: begin
          wr_idx <= '0;
          rd_idx <= '0;
          if (valid_i) begin
            key_N_o <= hdr_key;
`ifdef SCYTALE_FEEDER_CHECKSUM_EN
            xor_acc <= data_i;
`endif
            state   <= ST_HDR_M;
          end
        end
        ST_HDR_M: begin
          if (valid_i) begin
            key_M_o <= hdr_key;
`ifdef SCYTALE_FEEDER_CHECKSUM_EN
            xor_acc <= xor_acc ^ data_i;
`endif
            if ((product == '0) || (product > PROD_W'(MAX_NOF_CHARS))) begin
              err_o  <= 1'b1;
              wr_idx <= '0;
              rd_idx <= '0;
              state  <= ST_IDLE;
            end else begin
              last_idx <= IDX_W'(product - PROD_W'(1));
              state    <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (valid_i) begin
            wr_idx <= wr_idx + IDX_W'(1);
`ifdef SCYTALE_FEEDER_CHECKSUM_EN
            xor_acc <= xor_acc ^ data_i;
            if (wr_idx == last_idx) begin
              state <= ST_CHECK;
            end
`else
            if (wr_idx == last_idx) begin
              busy_o <= 1'b1;
              state  <= ST_DRAIN;
            end
`endif
          end
        end
`ifdef SCYTALE_FEEDER_CHECKSUM_EN
        ST_CHECK: begin
          if (valid_i) begin
            if (data_i == xor_acc) begin
              busy_o <= 1'b1;
              state  <= ST_DRAIN;
            end else begin
              err_o  <= 1'b1;
              wr_idx <= '0;
              rd_idx <= '0;
              state  <= ST_IDLE;
            end
          end
        end
`endif
        ST_DRAIN: begin
          tok_sel <= 1'b0;
          valid_o <= 1'b1;
          rd_idx  <= rd_idx + IDX_W'(1);
          if (rd_idx == last_idx) begin
            state <= ST_TOKEN;
          end
        end
        ST_TOKEN: begin
          tok_sel <= 1'b1;
          valid_o <= 1'b1;
          state   <= ST_WAIT_HI;
        end
        ST_WAIT_HI: begin
          if (dec_busy_i) begin
            state <= ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (!dec_busy_i) begin
            busy_o <= 1'b0;
            wr_idx <= '0;
            rd_idx <= '0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scytale_frame_feeder.sv
// Self-checking bench for scytale_frame_feeder. A reference model built from
// the frame rules (payload followed by the token, rejection when the key
// product is 0 or above the buffer size) predicts every output stream.
// Directed frames cover the key scenarios; random frames cover the rest.
module tb_scytale_frame_feeder;

  localparam int         MAXC  = 50;
  localparam logic [7:0] TOKEN = 8'hFA;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       dec_busy_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic [7:0] key_N_o;
  logic [7:0] key_M_o;
  logic       busy_o;
  logic       err_o;

  scytale_frame_feeder #(
    .D_WIDTH                (8),
    .KEY_WIDTH              (8),
    .MAX_NOF_CHARS          (MAXC),
    .START_DECRYPTION_TOKEN (TOKEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .dec_busy_i (dec_busy_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .key_N_o    (key_N_o),
    .key_M_o    (key_M_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  int         neg_cyc = 0;
  logic [7:0] out_data[$];
  int         out_stamp[$];
  int         err_stamp[$];

  // Monitor: log every valid output byte and every error pulse with the
  // index of the falling edge on which it was seen.
  always @(negedge clk) begin
    neg_cyc = neg_cyc + 1;
    if (valid_o) begin
      out_data.push_back(data_o);
      out_stamp.push_back(neg_cyc);
    end
    if (err_o) begin
      err_stamp.push_back(neg_cyc);
    end
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  int         n_checks = 0;
  int         n_fail = 0;
  int         last_stamp = 0;
  int         bad_stamp = 0;
  logic [7:0] pay_q[$];
  logic [7:0] frame_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] kn;
  logic [7:0] km;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: frame bytes to send and the output stream it must
  // produce (payload in order, then the token).
  task automatic buildFrame(input logic [7:0] n, input logic [7:0] m);
    logic [7:0] x;
    frame_q = {};
    frame_q.push_back(n);
    frame_q.push_back(m);
    x = n ^ m;
    foreach (pay_q[i]) begin
      frame_q.push_back(pay_q[i]);
      x = x ^ pay_q[i];
    end
`ifdef SCYTALE_FEEDER_CHECKSUM_EN
    frame_q.push_back(x);
`endif
    exp_q = pay_q;
    exp_q.push_back(TOKEN);
  endtask

  task automatic randomPayload(input int len);
    pay_q = {};
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) pay_q.push_back(TOKEN);
      else pay_q.push_back(8'($urandom));
    end
  endtask

  // Drive the frame bytes back to back; remember the falling-edge index
  // right after the last byte was sampled.
  task automatic applyStimulus();
    foreach (frame_q[i]) begin
      data_i  = frame_q[i];
      valid_i = 1'b1;
      @(posedge clk);
      #1;
    end
    valid_i    = 1'b0;
    data_i     = 8'($urandom);
    last_stamp = neg_cyc;
  endtask

  task automatic clearLogs();
    out_data  = {};
    out_stamp = {};
    err_stamp = {};
  endtask

  // Accepted frame: payload two cycles after the last input byte, no gaps,
  // token right after, keys held, busy until the decryptor handshake ends.
  task automatic checkGoodFrame(input logic [7:0] n, input logic [7:0] m);
    int l;
    l = exp_q.size();
    @(negedge clk); #1;
    checkOutput("gap_before_drain", valid_o, 1'b0);
    checkOutput("busy_in_drain", busy_o, 1'b1);
    repeat (l) @(negedge clk);
    #1;
    checkOutput("out_count", out_data.size(), l);
    foreach (exp_q[i]) begin
      if (i < out_data.size()) begin
        checkOutput("out_data", out_data[i], exp_q[i]);
        checkOutput("out_stamp", out_stamp[i], last_stamp + 2 + i);
      end
    end
    checkOutput("key_N", key_N_o, n);
    checkOutput("key_M", key_M_o, m);
    checkOutput("no_err", err_stamp.size(), 0);
    @(negedge clk); #1;
    checkOutput("valid_after_token", valid_o, 1'b0);
    checkOutput("data_hold", data_o, TOKEN);
    repeat ($urandom_range(1, 4)) begin
      valid_i = 1'($urandom_range(0, 1));
      data_i  = 8'($urandom);
      @(negedge clk); #1;
      checkOutput("busy_wait_hi", busy_o, 1'b1);
    end
    valid_i    = 1'b0;
    dec_busy_i = 1'b1;
    @(negedge clk); #1;
    checkOutput("busy_wait_lo", busy_o, 1'b1);
    checkOutput("key_N_hold", key_N_o, n);
    dec_busy_i = 1'b0;
    @(negedge clk); #1;
    checkOutput("busy_released", busy_o, 1'b0);
    checkOutput("no_extra_out", out_data.size(), l);
    clearLogs();
  endtask

  // Rejected frame: a single err pulse one cycle after the deciding byte.
  task automatic checkReject(input int ref_stamp);
    checkOutput("err_count", err_stamp.size(), 1);
    if (err_stamp.size() > 0) checkOutput("err_stamp", err_stamp[0], ref_stamp + 1);
    checkOutput("reject_no_out", out_data.size(), 0);
    err_stamp = {};
  endtask

  initial begin
    $display("[TB] scytale_frame_feeder bench starting");
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_valid", valid_o, 1'b0);
    checkOutput("rst_data", data_o, 8'h00);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_err", err_o, 1'b0);
    checkOutput("rst_key_N", key_N_o, 8'h00);
    checkOutput("rst_key_M", key_M_o, 8'h00);
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Basic frame 3x2 "ABCDEF".
    pay_q = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    buildFrame(8'd3, 8'd2);
    applyStimulus();
    checkGoodFrame(8'd3, 8'd2);

    // Zero key, then a frame starting in the very next cycle.
    pay_q = {};
    buildFrame(8'd0, 8'd5);
    frame_q = {8'd0, 8'd5};
    applyStimulus();
    bad_stamp = last_stamp;
    pay_q = {8'h11, 8'h22};
    buildFrame(8'd1, 8'd2);
    applyStimulus();
    checkReject(bad_stamp);
    checkGoodFrame(8'd1, 8'd2);

    // Oversized frame 8x8 and the first illegal length 3x17.
    frame_q = {8'd8, 8'd8};
    applyStimulus();
    repeat (2) @(negedge clk);
    #1;
    checkReject(last_stamp);
    checkOutput("reject_busy", busy_o, 1'b0);
    frame_q = {8'd3, 8'd17};
    applyStimulus();
    repeat (2) @(negedge clk);
    #1;
    checkReject(last_stamp);

    // Token value inside payload is plain data.
    pay_q = {TOKEN, 8'h41};
    buildFrame(8'd2, 8'd1);
    applyStimulus();
    checkGoodFrame(8'd2, 8'd1);

    // Largest legal frame 5x10 and smallest 1x1.
    randomPayload(MAXC);
    buildFrame(8'd5, 8'd10);
    applyStimulus();
    checkGoodFrame(8'd5, 8'd10);
    randomPayload(1);
    buildFrame(8'd1, 8'd1);
    applyStimulus();
    checkGoodFrame(8'd1, 8'd1);

    // Reset while the third byte is on the output.
    pay_q = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    buildFrame(8'd3, 8'd2);
    applyStimulus();
    repeat (4) @(negedge clk);
    #2;
    checkOutput("pre_reset_byte3", data_o, 8'h43);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", valid_o, 1'b0);
    checkOutput("abort_busy", busy_o, 1'b0);
    checkOutput("abort_data", data_o, 8'h00);
    checkOutput("abort_key_N", key_N_o, 8'h00);
    checkOutput("abort_out_count", out_data.size(), 3);
    @(negedge clk);
    rst_n = 1'b1;
    clearLogs();
    #1;
    pay_q = {8'h55, 8'h66, 8'h77, 8'h88};
    buildFrame(8'd2, 8'd2);
    applyStimulus();
    checkGoodFrame(8'd2, 8'd2);

`ifdef SCYTALE_FEEDER_CHECKSUM_EN
    // Checksum accepted (33) and rejected (34).
    pay_q = {8'h10, 8'h20};
    buildFrame(8'd1, 8'd2);
    checkOutput("model_checksum", frame_q[4], 8'h33);
    applyStimulus();
    checkGoodFrame(8'd1, 8'd2);
    frame_q[4] = 8'h34;
    applyStimulus();
    repeat (2) @(negedge clk);
    #1;
    checkReject(last_stamp);
`endif

    // Random legal frames interleaved with random rejected headers.
    for (int f = 0; f < 8; f++) begin
      kn = 8'($urandom_range(1, 10));
      km = 8'($urandom_range(1, MAXC / int'(kn)));
      randomPayload(int'(kn) * int'(km));
      buildFrame(kn, km);
      applyStimulus();
      checkGoodFrame(kn, km);
      kn = 8'($urandom_range(0, 20));
      if (kn == 8'd0) km = 8'($urandom);
      else if ($urandom_range(0, 2) == 0) km = 8'd0;
      else km = 8'($urandom_range(MAXC / int'(kn) + 1, 255));
      frame_q = {kn, km};
      applyStimulus();
      repeat (2) @(negedge clk);
      #1;
      checkReject(last_stamp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
